// File: rtl/pc_sequencer.sv
// Fetch/decode/execute control FSM for the 8-bit CPU. Sequences the external
// pcCounter, loads IR from instruction memory and hands execute ops to the datapath.
module pc_sequencer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] PC,
  output logic              mem_rd,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              zero_flag,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              PC_en,
  output logic              PC_inc,
  output logic [ADDR_W-1:0] PC_load,
  output logic [DATA_W-1:0] ir,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_OPERAND,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JMP = 4'h1;
  localparam logic [3:0] OP_JZ  = 4'h2;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state, state_nxt;
  logic       ir_load;
  logic       cnt_inc;
  logic       taken;
  logic [3:0] opcode;

  // PC is only consumed by instruction memory outside this block.
  logic unused_pc;
  assign unused_pc = ^PC;

  assign opcode = ir[DATA_W-1 -: 4];
  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ir        <= '0;
      instr_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= mem_rdata;
      if (cnt_inc) instr_cnt <= instr_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    mem_rd     = 1'b0;
    exec_start = 1'b0;
    PC_en      = 1'b0;
    PC_inc     = 1'b0;
    PC_load    = '0;
    ir_load    = 1'b0;
    cnt_inc    = 1'b0;
    taken      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          PC_en     = 1'b1;
          PC_inc    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_NOP: begin
            cnt_inc   = 1'b1;
            state_nxt = S_FETCH;
          end
          OP_HLT: begin
            cnt_inc   = 1'b1;
            state_nxt = S_HALT;
          end
          OP_JMP, OP_JZ: state_nxt = S_OPERAND;
          default: begin
            exec_start = 1'b1;
            state_nxt  = S_EXEC;
          end
        endcase
      end
      S_OPERAND: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          taken   = (opcode == OP_JMP) || ((opcode == OP_JZ) && zero_flag);
          PC_en   = 1'b1;
          cnt_inc = 1'b1;
          // Not-taken branches still advance PC past the operand byte.
          if (taken) PC_load = ADDR_W'(mem_rdata);
          else       PC_inc  = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          cnt_inc   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
